// File: rtl/rings_pkg.sv
// Shared definitions for the rings parameter scheduler: register map,
// reset defaults and the nibble-transaction FSM states.
package rings_pkg;

  localparam int NUM_REGS = 6;

  // Register addresses carried in the first nibble of a write
  localparam logic [2:0] REG_X       = 3'd0;
  localparam logic [2:0] REG_Y       = 3'd1;
  localparam logic [2:0] REG_SPACING = 3'd2;
  localparam logic [2:0] REG_COLOR   = 3'd3;
  localparam logic [2:0] REG_SPEED   = 3'd4;
  localparam logic [2:0] REG_CTRL    = 3'd5;

  // Highest implemented address; 6 and 7 are reserved
  localparam logic [2:0] REG_LAST    = REG_CTRL;

  // Power-on values for both shadow and active banks
  localparam logic [7:0] RST_X       = 8'h50;
  localparam logic [7:0] RST_Y       = 8'h3C;
  localparam logic [7:0] RST_SPACING = 8'h10;
  localparam logic [7:0] RST_COLOR   = 8'h3F;
  localparam logic [7:0] RST_SPEED   = 8'h01;
  localparam logic [7:0] RST_CTRL    = 8'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_ADDR = 2'd1,
    GOT_HI   = 2'd2
  } sched_state_e;

  function automatic logic [7:0] reg_default(input logic [2:0] idx);
    logic [7:0] val;
    val = 8'h00;
    case (idx)
      REG_X:       val = RST_X;
      REG_Y:       val = RST_Y;
      REG_SPACING: val = RST_SPACING;
      REG_COLOR:   val = RST_COLOR;
      REG_SPEED:   val = RST_SPEED;
      REG_CTRL:    val = RST_CTRL;
      default:     val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rings_sync_edge.sv
// Synchronizer chain for an asynchronous pin strobe followed by a
// rising-edge detector. rise is a one-cycle pulse built only from flops.
module rings_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the metastability chain, then keep one more
  // stage of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rings_param_sched.sv
// Frame-synchronous parameter scheduler. Nibble writes land in a shadow
// bank; a commit command arms a copy of shadow into the active bank at the
// next frame_start. The animation phase advances once per frame.
//
// Pin protocol: each rising edge of strobe_in carries one nibble on nib_in.
// A nibble with bit3 set is a commit command; otherwise it starts a write
// of the form {addr, data_hi, data_lo}. There is no back-pressure: ack
// toggles once per completed write or commit so the host can pace itself.
module rings_param_sched
  import rings_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PHASE_W     = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strobe_in,
  input  logic [3:0]         nib_in,
  input  logic               frame_start,
  output logic [7:0]         ring_x,
  output logic [7:0]         ring_y,
  output logic [7:0]         ring_spacing,
  output logic [7:0]         ring_color,
  output logic [7:0]         anim_speed,
  output logic [7:0]         anim_ctrl,
  output logic [PHASE_W-1:0] phase,
  output logic               ack,
  output logic               pending,
  output logic               err,
  output logic [1:0]         state_dbg
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic             nib;
  sched_state_e     state;
  logic [2:0]       addr_q;
  logic [3:0]       data_hi_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             ack_q;
  logic             pending_q;
  logic             err_q;
  logic [7:0]       shadow [NUM_REGS];
  logic [7:0]       active [NUM_REGS];
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] speed_ext;

  rings_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (strobe_in),
    .rise     (nib)
  );

  // Transaction FSM: assembles nibbles, writes shadow, arms commits and
  // aborts a stalled transaction after TIMEOUT idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_hi_q <= '0;
      tmo_cnt   <= '0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= reg_default(3'(i));
      end
    end else begin
      // The frame that applies a commit retires it; a commit command in
      // the same cycle re-arms it for the following frame
      if (frame_start && pending_q) begin
        pending_q <= 1'b0;
      end

      if (nib || state == IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (nib) begin
            if (nib_in[3]) begin
              pending_q <= 1'b1;
              err_q     <= 1'b0;
              ack_q     <= ~ack_q;
            end else begin
              addr_q <= nib_in[2:0];
              state  <= GOT_ADDR;
            end
          end
        end
        GOT_ADDR: begin
          if (nib) begin
            data_hi_q <= nib_in;
            state     <= GOT_HI;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
        GOT_HI: begin
          if (nib) begin
            // Reserved addresses complete the handshake but store nothing
            if (addr_q <= REG_LAST) begin
              shadow[addr_q] <= {data_hi_q, nib_in};
            end
            ack_q <= ~ack_q;
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign speed_ext = PHASE_W'(active[REG_SPEED]);

  // Frame-time update: advance phase from the pre-commit active values,
  // then copy the whole shadow bank if a commit is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= reg_default(3'(i));
      end
    end else if (frame_start) begin
      if (!active[REG_CTRL][0]) begin
        if (active[REG_CTRL][1]) begin
          phase_q <= phase_q - speed_ext;
        end else begin
          phase_q <= phase_q + speed_ext;
        end
      end
      if (pending_q) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  assign ring_x       = active[REG_X];
  assign ring_y       = active[REG_Y];
  assign ring_spacing = active[REG_SPACING];
  assign ring_color   = active[REG_COLOR];
  assign anim_speed   = active[REG_SPEED];
  assign anim_ctrl    = active[REG_CTRL];
  assign phase        = phase_q;
  assign ack          = ack_q;
  assign pending      = pending_q;
  assign err          = err_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_rings_param_sched.sv
// Bench for rings_param_sched: drives nibble transactions over the strobe
// pin, keeps a reference model of shadow/active/phase, and compares each
// ack event against a queue of expected {pending, err} values.
module tb_rings_param_sched;

  localparam int SYNC_STAGES = 2;
  localparam int PHASE_W     = 8;
  localparam int TIMEOUT     = 1024;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               strobe_in;
  logic [3:0]         nib_in;
  logic               frame_start;
  logic [7:0]         ring_x, ring_y, ring_spacing, ring_color, anim_speed, anim_ctrl;
  logic [PHASE_W-1:0] phase;
  logic               ack, pending, err;
  logic [1:0]         state_dbg;

  always #5 clk = ~clk;

  rings_param_sched #(
    .SYNC_STAGES (SYNC_STAGES),
    .PHASE_W     (PHASE_W),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .strobe_in    (strobe_in),
    .nib_in       (nib_in),
    .frame_start  (frame_start),
    .ring_x       (ring_x),
    .ring_y       (ring_y),
    .ring_spacing (ring_spacing),
    .ring_color   (ring_color),
    .anim_speed   (anim_speed),
    .anim_ctrl    (anim_ctrl),
    .phase        (phase),
    .ack          (ack),
    .pending      (pending),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_shadow [6];
  logic [7:0] m_active [6];
  logic [7:0] m_phase;
  logic       m_pending, m_err, m_ack;

  task automatic model_reset();
    m_shadow[0] = 8'h50; m_shadow[1] = 8'h3C; m_shadow[2] = 8'h10;
    m_shadow[3] = 8'h3F; m_shadow[4] = 8'h01; m_shadow[5] = 8'h00;
    for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
    m_phase = 8'h00; m_pending = 1'b0; m_err = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_frame();
    if (!m_active[5][0]) begin
      if (m_active[5][1]) m_phase = m_phase - m_active[4];
      else                m_phase = m_phase + m_active[4];
    end
    if (m_pending) begin
      for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_x"},       ring_x,       m_active[0]);
    check_val({tag, "_y"},       ring_y,       m_active[1]);
    check_val({tag, "_spacing"}, ring_spacing, m_active[2]);
    check_val({tag, "_color"},   ring_color,   m_active[3]);
    check_val({tag, "_speed"},   anim_speed,   m_active[4]);
    check_val({tag, "_ctrl"},    anim_ctrl,    m_active[5]);
    check_val({tag, "_phase"},   phase,        m_phase);
    check_val({tag, "_ack"},     ack,          m_ack);
    check_val({tag, "_pending"}, pending,      m_pending);
    check_val({tag, "_err"},     err,          m_err);
  endtask

  // ---------------- scoreboard: expected {pending, err} per ack ----------------
  logic [1:0] exp_q [$];
  logic       ack_prev;
  logic [1:0] mon_e;
  int         ack_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      ack_prev = 1'b0;
    end else if (ack !== ack_prev) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check_val("ack_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("ack_txn_pending_err", {30'd0, pending, err}, {30'd0, mon_e});
      end
      ack_prev = ack;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    nib_in    = n;
    strobe_in = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    strobe_in = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  task automatic send_write(input logic [2:0] a, input logic [7:0] d);
    send_nib({1'b0, a});
    send_nib(d[7:4]);
    m_ack = ~m_ack;
    if (a < 3'd6) m_shadow[a] = d;
    exp_q.push_back({m_pending, m_err});
    send_nib(d[3:0]);
  endtask

  task automatic send_commit();
    m_pending = 1'b1;
    m_err     = 1'b0;
    m_ack     = ~m_ack;
    exp_q.push_back({m_pending, m_err});
    send_nib(4'h8);
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    model_frame();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Commit nibble lands in the very cycle frame_start is sampled
  task automatic send_commit_with_frame();
    model_frame();
    m_pending = 1'b1;
    m_err     = 1'b0;
    m_ack     = ~m_ack;
    exp_q.push_back({m_pending, m_err});
    @(negedge clk);
    nib_in    = 4'h8;
    strobe_in = 1'b1;
    repeat (SYNC_STAGES) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    strobe_in = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  wait_cyc;
    logic saw_err;

    rst = 1'b1; strobe_in = 1'b0; nib_in = 4'h0; frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_regs("rst");
    check_val("rst_state", state_dbg, 2'd0);

    // Spacing write and commit
    send_write(3'd2, 8'hA5);
    send_commit();
    check_val("pre_commit_spacing", ring_spacing, 8'h10);
    check_val("pre_commit_pending", pending, 1'b1);
    check_val("pre_commit_ack_count", ack_cnt, 2);
    check_regs("pre_commit");
    frame_pulse();
    @(negedge clk);
    check_val("post_commit_spacing", ring_spacing, 8'hA5);
    check_val("post_commit_pending", pending, 1'b0);
    check_regs("post_commit");

    // Phase forward, reverse and wrap
    pulse_reset();
    send_write(3'd4, 8'h03);
    send_commit();
    frame_pulse();                      // advances by old speed 1
    repeat (10) frame_pulse();
    @(negedge clk);
    check_val("phase_forward", phase, 8'd31);
    check_regs("phase_fwd");
    send_write(3'd5, 8'h02);
    send_commit();
    frame_pulse();                      // still forward: 34
    repeat (10) frame_pulse();
    @(negedge clk);
    check_val("phase_reverse", phase, 8'd4);
    send_write(3'd4, 8'hFF);
    send_write(3'd5, 8'h00);
    send_commit();
    frame_pulse();                      // reverse by 3: 1
    repeat (2) frame_pulse();
    @(negedge clk);
    check_val("phase_wrap", phase, 8'hFF);
    check_regs("phase_wrap");

    // Paused frames leave phase untouched
    send_write(3'd5, 8'h01);
    send_commit();
    frame_pulse();
    repeat (3) frame_pulse();
    @(negedge clk);
    check_regs("paused");

    // Reserved address: handshake only
    send_write(3'd6, 8'h77);
    send_commit();
    frame_pulse();
    @(negedge clk);
    check_regs("reserved");

    // Timeout mid-transaction
    send_nib(4'h1);
    send_nib(4'h7);
    repeat (TIMEOUT - 40) @(negedge clk);
    check_val("tmo_not_early_err", err, 1'b0);
    check_val("tmo_not_early_state", state_dbg, 2'd2);
    saw_err  = 1'b0;
    wait_cyc = 0;
    while (!saw_err && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
      if (err === 1'b1) saw_err = 1'b1;
    end
    check_val("tmo_err_seen", saw_err, 1'b1);
    check_val("tmo_state_idle", state_dbg, 2'd0);
    m_err = 1'b1;
    check_regs("tmo");
    send_commit();
    check_val("tmo_err_cleared", err, 1'b0);
    frame_pulse();
    @(negedge clk);
    check_regs("tmo_commit");

    // Commit command coincident with frame_start
    send_write(3'd3, 8'h11);
    send_commit_with_frame();
    check_val("coinc_color_hold", ring_color, m_active[3]);
    check_val("coinc_pending", pending, 1'b1);
    check_regs("coinc");
    frame_pulse();
    @(negedge clk);
    check_val("coinc_color_applied", ring_color, 8'h11);
    check_regs("coinc_next");

    // Reset mid-transaction
    send_nib(4'h0);
    send_nib(4'h5);
    pulse_reset();
    check_regs("mid_rst");
    check_val("mid_rst_state", state_dbg, 2'd0);
    send_write(3'd0, 8'h12);
    send_commit();
    frame_pulse();
    @(negedge clk);
    check_val("after_rst_x", ring_x, 8'h12);
    check_regs("after_rst");

    // A few random writes with commits
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ra;
      logic [7:0] rd;
      ra = 3'($urandom_range(0, 3));
      rd = 8'($urandom_range(0, 255));
      send_write(ra, rd);
      send_commit();
      frame_pulse();
      @(negedge clk);
      check_regs("rand");
    end

    repeat (5) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rings_param_sched.md
# rings_param_sched

Frame-synchronous parameter scheduler for the rings renderer. Accepts 3-nibble register writes over a slow pin-level strobe and nibble interface, and holds them in shadow registers. Commits shadow to active registers atomically at the next frame start after a commit command. Advances the per-frame animation phase. Sits between the `ui_in` pin decode at top level and the ring drawing datapath.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `strobe_in`; minimum 2.
- `PHASE_W`, 8: animation phase width; minimum 8.
- `TIMEOUT`, 1024: idle cycles allowed mid-transaction before abort.
- `clk` in 1: single clock for all state.
- `rst` in 1: reset, asynchronous and active-high.
- `strobe_in` in 1: asynchronous pin strobe; each rising edge delivers one nibble.
- `nib_in` in 4: nibble, stable ≥ SYNC_STAGES+2 cycles around the strobe edge.
- `frame_start` in 1: one-cycle pulse at start of vblank, synchronous.
- `ring_x`, `ring_y`, `ring_spacing`, `ring_color`, `anim_speed`, `anim_ctrl` out 8 each: active registers 0–5.
- `phase` out PHASE_W: animation phase.
- `ack` out 1: toggles once per completed write or commit command.
- `pending` out 1: commit requested, not yet applied.
- `err` out 1: sticky transaction-timeout flag.

## Operation
- Reset values:
  - Active and shadow registers: x=0x50, y=0x3C, spacing=0x10, color=0x3F, speed=0x01, ctrl=0x00.
  - phase=0, ack=0, pending=0, err=0, FSM=IDLE, timeout counter=0.
- `strobe_in` passes through SYNC_STAGES flops, then one more flop for rising-edge detect. `nib` is the event; `nib_in` is sampled on the `nib` cycle.
- FSM states and transitions:
  - IDLE, `nib` with bit3=1: commit command. pending←1, err←0, ack toggles, stay IDLE.
  - IDLE, `nib` with bit3=0: addr←nib[2:0], go to GOT_ADDR.
  - GOT_ADDR, `nib`: data_hi←nib, go to GOT_HI.
  - GOT_HI, `nib`: shadow[addr]←{data_hi,nib}, ack toggles, go to IDLE.
  - addr 6 and 7 are reserved: the write is discarded, ack still toggles.
- Timeout:
  - Counter clears on every `nib` and in IDLE; increments otherwise.
  - In GOT_ADDR or GOT_HI, when count reaches TIMEOUT-1: go to IDLE, err←1, no register write.
- Commit: on `frame_start` with pending=1, all six active←shadow in one cycle and pending←0.
- Phase:
  - On `frame_start` with anim_ctrl[0]=0 (not paused): phase += anim_speed, or phase −= anim_speed if anim_ctrl[1]=1.
  - Modulo 2^PHASE_W, speed zero-extended.
  - Uses the active values present before that cycle's commit.
- anim_ctrl[7:2] are stored but have no function here.

## Timing
- Strobe rise before clock edge k → `nib` asserted in cycle k+SYNC_STAGES. Register write, ack toggle and pending set land on that cycle's closing edge.
- Commit command `nib` coincident with `frame_start`: frame_start sees the old pending=0. Commit happens at the following frame_start.
- Shadow write coincident with a commit: active receives the pre-write shadow value; the new value waits for the next commit.
- Commit command while pending=1: pending stays 1; ack still toggles.
- `frame_start` does not disturb the FSM; transactions straddle frames freely.
- Reset asserted mid-transaction: immediate return to all reset values, partial nibbles lost.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `rings_pkg` holds:
  - register address localparams (REG_X=0 … REG_CTRL=5);
  - reset-default constants;
  - FSM state enum {IDLE, GOT_ADDR, GOT_HI}.
- Sub-module `rings_sync_edge` (SYNC_STAGES parameter): synchronizer chain plus rising-edge pulse output. Reused for other pin strobes.
- Shadow and active banks are 6×8 flop arrays in the top of this block; no memories.

## Test plan
- Reset, then read outputs: x=0x50, y=0x3C, spacing=0x10, color=0x3F, speed=1, ctrl=0, phase=0, ack=0, pending=0, err=0.
- Send nibbles 0x2,0xA,0x5, then 0x8, then a frame_start pulse:
  - before commit: ring_spacing stays 0x10, pending=1, ack has toggled twice;
  - after frame_start: ring_spacing=0xA5, pending=0.
- Ten frame_start pulses with speed=3 → phase=30.
  - Set ctrl=0x02, commit, 10 more pulses → phase=0.
  - Set speed=0xFF, ctrl=0, 2 pulses → phase wraps to 0xFE.
- Send nibbles 0x1,0x7 and stop for TIMEOUT cycles:
  - err=1, FSM back in IDLE, ring_y unchanged after commit;
  - next commit command clears err.
- Commit command `nib` in the same cycle as frame_start → no change that frame; values apply at the next frame_start.
- Assert rst after the second nibble of a write to addr 0 → all reset values.
  - A following full write 0x0,0x1,0x2 plus commit → ring_x=0x12.
